jtag_tap_responder: RTL and testbench
=====================================

JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4: instruction register width, minimum 2.
REQ-002 SHALL have parameter USER_DR_WIDTH, default 8: user data register width, minimum 1.
REQ-003 SHALL have parameter IDCODE_VALUE, default 32'h1234_5003: device ID, bit 0 fixed to 1.
REQ-004 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tck  input  1  JTAG test clock, sampled asynchronously; frequency at most clock/4.
REQ-007 SHALL have port tms  input  1  JTAG mode select.
REQ-008 SHALL have port tdi  input  1  JTAG serial data in.
REQ-009 SHALL have port tdo  output  1  JTAG serial data out.
REQ-010 SHALL have port tdo_en  output  1  tdo valid/drive enable.
REQ-011 SHALL have port user_dr_in  input  USER_DR_WIDTH  value captured into USER DR.
REQ-012 SHALL have port user_dr_out  output  USER_DR_WIDTH  last updated USER DR value.
REQ-013 SHALL have port user_dr_update  output  1  single-clock pulse on USER DR update.

Function
REQ-014 SHALL synchronize tck, tms and tdi through 2 flops and detect tck edges from the synchronized stage and one further delayed copy; all TAP actions SHALL occur in the clock cycle of edge detection.
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR and the equivalent IR states, advancing only on detected tck rising edges using synchronized tms.
REQ-016 SHALL reach TLR from any state after 5 consecutive rising tck edges with tms=1.
REQ-017 SHALL decode instructions: 1 = IDCODE, 8 = USER, all-ones = BYPASS, any other value = BYPASS.
REQ-018 On entry to TLR, SHALL load IR with IDCODE.
REQ-019 CAP_IR SHALL load the IR shift register with binary ...0001 (LSBs 01).
REQ-020 CAP_DR SHALL load the selected DR: BYPASS=0, IDCODE=IDCODE_VALUE, USER=user_dr_in.
REQ-021 SH_IR/SH_DR SHALL shift right, LSB first, with tdi entering the MSB, on each rising edge while in the shift state.
REQ-022 UPD_IR SHALL copy the IR shift register to the active IR; UPD_DR with USER selected SHALL copy the DR shift register to user_dr_out and pulse user_dr_update high for exactly one clock.
REQ-023 tdo SHALL be updated on each detected falling tck edge to the LSB of the active shift register while in SH_IR/SH_DR; tdo_en SHALL go 1 on that falling edge and 0 on the first falling edge outside a shift state.
REQ-024 Outside shift states, tdo SHALL hold 0.
REQ-025 Simultaneous rising and falling edge detection SHALL be impossible by construction; a tck glitch shorter than 2 clocks SHALL be ignored or treated as one full period, never as a partial shift.

Reset
REQ-026 reset low SHALL asynchronously force: FSM=TLR, IR=IDCODE, all shift registers 0, tdo=0, tdo_en=0, user_dr_out=0, user_dr_update=0, synchronizers 0.
REQ-027 Reset asserted mid-shift SHALL abort the shift with no update of IR or user_dr_out.

Configuration
REQ-028 Macro JTAG_TAP_IDCODE_EN defined: IDCODE register and instruction implemented as specified.
REQ-029 Macro JTAG_TAP_IDCODE_EN undefined: no IDCODE register; instruction 1 SHALL select BYPASS; TLR SHALL load IR with BYPASS (all-ones).

Verification
REQ-030 Release reset, with JTAG_TAP_IDCODE_EN defined, pass through TLR->RTI->SEL_DR->CAP_DR, then 32 SH_DR shifts -> tdo sequence equals 32'h1234_5003 LSB first (first bit 1), tdo_en=1 throughout.
REQ-031 Load IR=4'hF, then in SH_DR shift tdi pattern 1,0,1,1 -> tdo returns 0,1,0,1 (one-bit delay, leading captured 0).
REQ-032 Load IR=4'h8, then shift 8'hA5 LSB first and UPD_DR -> user_dr_out=8'hA5, user_dr_update high exactly one clock; with user_dr_in=8'h3C, the next capture/shift -> tdo yields 8'h3C LSB first.
REQ-033 From SH_DR, drive tms=1 for 5 rising tck edges -> FSM=TLR, IR=IDCODE, tdo_en=0.
REQ-034 Assert reset after 3 shift edges of a USER DR write -> user_dr_out stays at its prior value, FSM=TLR, tdo=0.
REQ-035 With JTAG_TAP_IDCODE_EN undefined, do the DR scan of REQ-030 -> first tdo bit 0 (BYPASS), then tdi echoed with one-bit delay.

Source files
------------

// File: rtl/jtag_tap_responder.sv
// rtl/jtag_tap_responder.sv - IEEE 1149.1 TAP responder oversampled on the system clock
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register and instruction.
module jtag_tap_responder #(
  parameter int          IR_WIDTH      = 4,
  parameter int          USER_DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1234_5003
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_dr_update
);

  localparam logic [3:0] TLR    = 4'd0;
  localparam logic [3:0] RTI    = 4'd1;
  localparam logic [3:0] SEL_DR = 4'd2;
  localparam logic [3:0] CAP_DR = 4'd3;
  localparam logic [3:0] SH_DR  = 4'd4;
  localparam logic [3:0] EX1_DR = 4'd5;
  localparam logic [3:0] PA_DR  = 4'd6;
  localparam logic [3:0] EX2_DR = 4'd7;
  localparam logic [3:0] UPD_DR = 4'd8;
  localparam logic [3:0] SEL_IR = 4'd9;
  localparam logic [3:0] CAP_IR = 4'd10;
  localparam logic [3:0] SH_IR  = 4'd11;
  localparam logic [3:0] EX1_IR = 4'd12;
  localparam logic [3:0] PA_IR  = 4'd13;
  localparam logic [3:0] EX2_IR = 4'd14;
  localparam logic [3:0] UPD_IR = 4'd15;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = '1;
`endif

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("jtag_tap_responder: IR_WIDTH must be at least 2");
  end
  if (USER_DR_WIDTH < 1) begin : g_bad_user_width
    $error("jtag_tap_responder: USER_DR_WIDTH must be at least 1");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("jtag_tap_responder: IDCODE_VALUE bit 0 must be 1");
  end

  logic [1:0]               tck_sync;
  logic [1:0]               tms_sync;
  logic [1:0]               tdi_sync;
  logic                     tck_dly;
  logic                     tck_rise;
  logic                     tck_fall;
  logic                     tms_s;
  logic                     tdi_s;
  logic [3:0]               state;
  logic [3:0]               next_state;
  logic [IR_WIDTH-1:0]      ir;
  logic [IR_WIDTH-1:0]      ir_shift;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic                     bypass_reg;
  logic                     sel_user;
  logic                     dr_lsb;

  // Edges come from one synchronized stage vs its delayed copy, so rise and fall are mutually exclusive.
  assign tck_rise = tck_sync[1] & ~tck_dly;
  assign tck_fall = ~tck_sync[1] & tck_dly;
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];
  assign sel_user = (32'(ir) == 32'd8);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tck_sync <= 2'b00;
      tms_sync <= 2'b00;
      tdi_sync <= 2'b00;
      tck_dly  <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck};
      tms_sync <= {tms_sync[0], tms};
      tdi_sync <= {tdi_sync[0], tdi};
      tck_dly  <= tck_sync[1];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:     next_state = tms_s ? TLR    : RTI;
      RTI:     next_state = tms_s ? SEL_DR : RTI;
      SEL_DR:  next_state = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms_s ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms_s ? UPD_DR : PA_DR;
      PA_DR:   next_state = tms_s ? EX2_DR : PA_DR;
      EX2_DR:  next_state = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms_s ? SEL_DR : RTI;
      SEL_IR:  next_state = tms_s ? TLR    : CAP_IR;
      CAP_IR:  next_state = tms_s ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms_s ? UPD_IR : PA_IR;
      PA_IR:   next_state = tms_s ? EX2_IR : PA_IR;
      EX2_IR:  next_state = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms_s ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_shift;
  logic        sel_idcode;

  assign sel_idcode = (ir == IR_IDCODE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idcode_shift <= '0;
    end else if (tck_rise && sel_idcode) begin
      if (state == CAP_DR) begin
        idcode_shift <= IDCODE_VALUE;
      end else if (state == SH_DR) begin
        idcode_shift <= {tdi_s, idcode_shift[31:1]};
      end
    end
  end
`endif

  always_comb begin
    dr_lsb = bypass_reg;
    if (sel_user) begin
      dr_lsb = user_shift[0];
    end
`ifdef JTAG_TAP_IDCODE_EN
    else if (sel_idcode) begin
      dr_lsb = idcode_shift[0];
    end
`endif
  end

  // Capture/shift act on the rising edge; update and tdo follow the falling edge as in 1149.1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= TLR;
      ir             <= IR_RESET;
      ir_shift       <= '0;
      user_shift     <= '0;
      bypass_reg     <= 1'b0;
      tdo            <= 1'b0;
      tdo_en         <= 1'b0;
      user_dr_out    <= '0;
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
      if (tck_rise) begin
        state <= next_state;
        case (state)
          CAP_IR: ir_shift <= IR_WIDTH'(1);
          SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          CAP_DR: begin
            bypass_reg <= 1'b0;
            if (sel_user) begin
              user_shift <= user_dr_in;
            end
          end
          SH_DR: begin
            bypass_reg <= tdi_s;
            if (sel_user) begin
              user_shift <= USER_DR_WIDTH'({tdi_s, user_shift} >> 1);
            end
          end
          default: ;
        endcase
        if (next_state == TLR) begin
          ir <= IR_RESET;
        end
      end
      if (tck_fall) begin
        if (state == UPD_IR) begin
          ir <= ir_shift;
        end
        if (state == UPD_DR && sel_user) begin
          user_dr_out    <= user_shift;
          user_dr_update <= 1'b1;
        end
        if (state == SH_IR) begin
          tdo    <= ir_shift[0];
          tdo_en <= 1'b1;
        end else if (state == SH_DR) begin
          tdo    <= dr_lsb;
          tdo_en <= 1'b1;
        end else begin
          tdo    <= 1'b0;
          tdo_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb/tb_jtag_tap_responder.sv - self-checking bench for jtag_tap_responder
// Honours JTAG_TAP_IDCODE_EN in the same way as the design.
module tb_jtag_tap_responder;

  localparam int          IRW = 4;
  localparam int          UDW = 8;
  localparam logic [31:0] IDC = 32'h1234_5003;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit HAS_IDCODE = 1'b1;
`else
  localparam bit HAS_IDCODE = 1'b0;
`endif
  localparam int IR_RST = HAS_IDCODE ? 1 : (1 << IRW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           tck = 1'b0;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           tdo;
  logic           tdo_en;
  logic [UDW-1:0] user_dr_in = '0;
  logic [UDW-1:0] user_dr_out;
  logic           user_dr_update;

  int n_vec = 0;
  int n_fail = 0;
  int upd_count = 0;
  bit last_en;

  jtag_tap_responder #(
    .IR_WIDTH      (IRW),
    .USER_DR_WIDTH (UDW),
    .IDCODE_VALUE  (IDC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tck            (tck),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .user_dr_in     (user_dr_in),
    .user_dr_out    (user_dr_out),
    .user_dr_update (user_dr_update)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (user_dr_update) upd_count <= upd_count + 1;

  // Reference model: TAP graph plus bit queues (front = bit next on tdo)
  typedef enum int {S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PADR, S_EX2DR, S_UPDDR,
                    S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAIR, S_EX2IR, S_UPDIR} tap_t;
  tap_t m_state;
  int   m_ir;
  int   m_user;
  bit   q_ir[$];
  bit   q_dr[$];
  bit   m_tdo, m_en, m_upd;

  function automatic tap_t tap_next(tap_t s, bit t);
    case (s)
      S_TLR:   return t ? S_TLR   : S_RTI;
      S_RTI:   return t ? S_SELDR : S_RTI;
      S_SELDR: return t ? S_SELIR : S_CAPDR;
      S_CAPDR: return t ? S_EX1DR : S_SHDR;
      S_SHDR:  return t ? S_EX1DR : S_SHDR;
      S_EX1DR: return t ? S_UPDDR : S_PADR;
      S_PADR:  return t ? S_EX2DR : S_PADR;
      S_EX2DR: return t ? S_UPDDR : S_SHDR;
      S_UPDDR: return t ? S_SELDR : S_RTI;
      S_SELIR: return t ? S_TLR   : S_CAPIR;
      S_CAPIR: return t ? S_EX1IR : S_SHIR;
      S_SHIR:  return t ? S_EX1IR : S_SHIR;
      S_EX1IR: return t ? S_UPDIR : S_PAIR;
      S_PAIR:  return t ? S_EX2IR : S_PAIR;
      S_EX2IR: return t ? S_UPDIR : S_SHIR;
      default: return t ? S_SELDR : S_RTI;
    endcase
  endfunction

  // 0 = BYPASS, 1 = IDCODE, 2 = USER
  function automatic int kind();
    if (m_ir == 8) return 2;
    if (m_ir == 1 && HAS_IDCODE) return 1;
    return 0;
  endfunction

  function automatic int q2int(input bit q[$]);
    int v = 0;
    foreach (q[i]) v = v | (int'(q[i]) << i);
    return v;
  endfunction

  function automatic void model_reset();
    m_state = S_TLR;
    m_ir = IR_RST;
    m_user = 0;
    q_ir = {};
    q_dr = {};
    m_tdo = 0;
    m_en = 0;
    m_upd = 0;
  endfunction

  function automatic void model_fall();
    m_upd = 0;
    m_en = (m_state == S_SHIR) || (m_state == S_SHDR);
    m_tdo = (m_state == S_SHIR) ? q_ir[0] : (m_state == S_SHDR) ? q_dr[0] : 1'b0;
    if (m_state == S_UPDIR) m_ir = q2int(q_ir);
    if (m_state == S_UPDDR && kind() == 2) begin
      m_user = q2int(q_dr);
      m_upd = 1;
    end
  endfunction

  function automatic void model_rise(bit t, bit d, logic [UDW-1:0] uin);
    logic [31:0] idv = IDC;
    case (m_state)
      S_CAPIR: begin
        q_ir = {};
        q_ir.push_back(1'b1);
        for (int i = 1; i < IRW; i++) q_ir.push_back(1'b0);
      end
      S_SHIR: begin
        void'(q_ir.pop_front());
        q_ir.push_back(d);
      end
      S_CAPDR: begin
        q_dr = {};
        case (kind())
          1:       for (int i = 0; i < 32; i++) q_dr.push_back(idv[i]);
          2:       for (int i = 0; i < UDW; i++) q_dr.push_back(uin[i]);
          default: q_dr.push_back(1'b0);
        endcase
      end
      S_SHDR: begin
        void'(q_dr.pop_front());
        q_dr.push_back(d);
      end
      default: ;
    endcase
    m_state = tap_next(m_state, t);
    if (m_state == S_TLR) m_ir = IR_RST;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // One full tck period: low phase (falling edge) then high phase (rising edge)
  task automatic tck_cycle(input bit t, input bit d, output bit tdo_s);
    int snap;
    snap = upd_count;
    tms = t;
    tdi = d;
    tck = 1'b0;
    repeat (3) @(negedge clock);
    model_fall();
    check("tdo", tdo, m_tdo);
    check("tdo_en", tdo_en, m_en);
    tdo_s = tdo;
    last_en = tdo_en;
    tck = 1'b1;
    repeat (3) @(negedge clock);
    model_rise(t, d, user_dr_in);
    check("upd_pulse", upd_count - snap, m_upd);
    check("user_dr_out", user_dr_out, m_user);
  endtask

  task automatic do_reset();
    int snap;
    snap = upd_count;
    reset = 1'b0;
    tck = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    repeat (4) @(negedge clock);
    model_reset();
    check("rst_tdo", tdo, 0);
    check("rst_tdo_en", tdo_en, 0);
    check("rst_user_dr_out", user_dr_out, 0);
    check("rst_upd", upd_count - snap, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic ir_scan(input logic [31:0] v, output logic [31:0] w);
    bit b;
    w = '0;
    tck_cycle(1, 0, b);
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    tck_cycle(0, 0, b);
    for (int i = 0; i < IRW; i++) begin
      tck_cycle(i == IRW - 1, v[i], b);
      w[i] = b;
    end
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
  endtask

  task automatic dr_scan(input logic [63:0] v, input int n, output logic [63:0] w,
                         output int en_cnt, output int pulses);
    bit b;
    int snap;
    snap = upd_count;
    w = '0;
    en_cnt = 0;
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    tck_cycle(0, 0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, v[i], b);
      w[i] = b;
      en_cnt += int'(last_en);
    end
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    pulses = upd_count - snap;
  endtask

  typedef struct {
    logic [3:0] ir;
    logic [7:0] uin;
    logic [7:0] din;
    logic [7:0] exp_tdo;
    logic [7:0] exp_out;
    int         exp_pulses;
  } vec_t;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    vec_t        tbl[6];
    logic [63:0] w;
    logic [31:0] iw;
    logic [31:0] pat;
    int          en_cnt, pulses, len, op;
    bit          b;

    tbl[0] = '{4'h8, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1};
    tbl[1] = '{4'hF, 8'h00, 8'hA5, 8'h4A, 8'hA5, 0};
    tbl[2] = '{4'h8, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 1};
    tbl[3] = '{4'h2, 8'h77, 8'hFF, 8'hFE, 8'h5A, 0};
    tbl[4] = '{4'h1, 8'h11, 8'h81, (HAS_IDCODE ? 8'h03 : 8'h02), 8'h5A, 0};
    tbl[5] = '{4'h0, 8'h99, 8'h01, 8'h02, 8'h5A, 0};

    do_reset();
    tck_cycle(0, 0, b);

    // 32-bit DR scan straight after reset: IDCODE, or BYPASS echo when IDCODE is absent
    pat = 32'h8F0C_3A65;
    dr_scan({32'h0, pat}, 32, w, en_cnt, pulses);
    check("reset_dr_scan", w[31:0], HAS_IDCODE ? IDC : {pat[30:0], 1'b0});
    check("reset_dr_scan_en", en_cnt, 32);
    check("reset_dr_scan_pulses", pulses, 0);

    foreach (tbl[k]) begin
      user_dr_in = tbl[k].uin;
      ir_scan({28'h0, tbl[k].ir}, iw);
      check("ir_capture", iw[IRW-1:0], 4'b0001);
      dr_scan({56'h0, tbl[k].din}, 8, w, en_cnt, pulses);
      check("tbl_tdo", w[7:0], tbl[k].exp_tdo);
      check("tbl_user_dr_out", user_dr_out, tbl[k].exp_out);
      check("tbl_pulses", pulses, tbl[k].exp_pulses);
      check("tbl_en", en_cnt, 8);
    end

    // BYPASS echo with one-bit delay
    ir_scan(32'hF, iw);
    dr_scan(64'b1101, 4, w, en_cnt, pulses);
    check("bypass_echo", w[3:0], 4'b1010);

    // Five tms=1 edges from SH_DR return to TLR with IR reset
    user_dr_in = 8'hFF;
    ir_scan(32'h8, iw);
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    tck_cycle(0, 0, b);
    tck_cycle(0, 1, b);
    for (int i = 0; i < 5; i++) tck_cycle(1, 0, b);
    check("tlr_tdo_en", last_en, 0);
    tck_cycle(0, 0, b);
    dr_scan(64'h0, 8, w, en_cnt, pulses);
    check("tlr_ir_reset", w[7:0], HAS_IDCODE ? 8'h03 : 8'h00);

    // Reset in the middle of a USER write
    ir_scan(32'h8, iw);
    dr_scan(64'h0, 8, w, en_cnt, pulses);
    check("pre_abort_out", user_dr_out, 8'h00);
    user_dr_in = 8'h5C;
    tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    tck_cycle(0, 0, b);
    for (int i = 0; i < 3; i++) tck_cycle(0, 1, b);
    do_reset();
    user_dr_in = 8'hFF;
    tck_cycle(0, 0, b);
    dr_scan(64'h0, 8, w, en_cnt, pulses);
    check("abort_tlr_ir", w[7:0], HAS_IDCODE ? 8'h03 : 8'h00);

    // Randomized mix of scans, walks and input changes against the model
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          case ($urandom_range(0, 3))
            0:       iw = 32'h1;
            1:       iw = 32'h8;
            2:       iw = 32'hF;
            default: iw = $urandom_range(0, 15);
          endcase
          ir_scan(iw, iw);
        end
        1: begin
          len = $urandom_range(1, 40);
          dr_scan({$urandom, $urandom}, len, w, en_cnt, pulses);
        end
        2: begin
          len = $urandom_range(1, 12);
          for (int i = 0; i < len; i++) tck_cycle($urandom_range(0, 1), $urandom_range(0, 1), b);
          for (int i = 0; i < 5; i++) tck_cycle(1, 0, b);
          tck_cycle(0, 0, b);
        end
        default: user_dr_in = UDW'($urandom);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
